// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: start bit, WIDTH data bits, optional parity, stop bit.
// Optional even-parity bit is enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TICK_DIV  = 100000000,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       btn,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] led
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef PISO_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic             btn0_q;
  logic             sout_d, busy_d, done_d;
  logic [WIDTH-1:0] led_d;
  logic             start, abort, tick_end;
  logic [WIDTH-1:0] shreg_shifted;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign start         = btn[0] & ~btn0_q;
  assign abort         = btn[1];
  assign tick_end      = (tick_q == TickLast);
  assign shreg_shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != StIdle) begin
      tick_d = tick_end ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StStart;
          shreg_d  = sw;
          tick_d   = '0;
          bitcnt_d = '0;
`ifdef PISO_TX_PARITY_EN
          parity_d = ^sw;
`endif
        end
      end
      StStart: begin
        if (tick_end) state_d = StData;
      end
      StData: begin
        if (tick_end) begin
          // Shift on the last bit too, so the register is empty during stop.
          shreg_d  = shreg_shifted;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BitLast) begin
            bitcnt_d = '0;
`ifdef PISO_TX_PARITY_EN
            state_d  = StParity;
`else
            state_d  = StStop;
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      StParity: begin
        if (tick_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (tick_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything outside idle; start-vs-abort in idle goes to start.
    if ((state_q != StIdle) && abort) begin
      state_d  = StIdle;
      shreg_d  = '0;
      tick_d   = '0;
      bitcnt_d = '0;
      done_d   = 1'b0;
    end

    // Outputs are a registered decode of the next state.
    busy_d = (state_d != StIdle);
    led_d  = busy_d ? shreg_d : '0;
    unique case (state_d)
      StIdle:   sout_d = 1'b1;
      StStart:  sout_d = 1'b0;
      StData:   sout_d = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
      StParity: sout_d = parity_d;
`endif
      StStop:   sout_d = 1'b1;
      default:  sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // Tracked through reset so a button held across release is not a fresh edge.
    btn0_q <= btn[0];
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      tick_q   <= '0;
      bitcnt_q <= '0;
      sout     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      led      <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      sout     <= sout_d;
      busy     <= busy_d;
      done     <= done_d;
      led      <= led_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one LSB-first and one MSB-first instance share all inputs.
// Parity checks are included when PISO_TX_PARITY_EN is defined.
module tb_piso_tx;

  localparam int TICK = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int NPER = 11;
`else
  localparam int NPER = 10;
`endif
  localparam int FL = NPER * TICK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic [1:0] btn = 2'b00;
  logic       sout_l, busy_l, done_l, sout_m, busy_m, done_m;
  logic [7:0] led_l, led_m;

  int checks   = 0;
  int failures = 0;

  logic       cap_sl [FL];
  logic       cap_sm [FL];
  logic       cap_busy [FL];
  logic       cap_done [FL];
  logic [7:0] cap_ll [FL];
  logic [7:0] cap_lm [FL];
  logic [1:0] post_busy, post_done, post2_done;

  piso_tx #(.WIDTH(8), .TICK_DIV(TICK), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .sout(sout_l), .busy(busy_l), .done(done_l), .led(led_l)
  );

  piso_tx #(.WIDTH(8), .TICK_DIV(TICK), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .sout(sout_m), .busy(busy_m), .done(done_m), .led(led_m)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq holds the data bits in transmission order, seq[7] sent first.
  function automatic logic exp_sout(input logic [7:0] seq, input logic par, input int c);
    int p;
    p = c / TICK;
    if (p == 0) return 1'b0;
    if (p <= 8) return seq[8-p];
`ifdef PISO_TX_PARITY_EN
    if (p == 9) return par;
`endif
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_led(input logic [7:0] data, input bit lsb, input int c);
    int p;
    int k;
    p = c / TICK;
    if (p > 8) return 8'h00;
    k = (p == 0) ? 0 : p - 1;
    return lsb ? (data >> k) : (data << k);
  endfunction

  // Starts a frame and records both instances for the whole frame plus two idle cycles.
  task automatic capture(input logic [7:0] data, input bit disturb);
    sw  = data;
    btn = 2'b01;
    step();
    btn = 2'b00;
    for (int c = 0; c < FL; c++) begin
      cap_sl[c]   = sout_l;
      cap_sm[c]   = sout_m;
      cap_busy[c] = busy_l & busy_m;
      cap_done[c] = done_l | done_m;
      cap_ll[c]   = led_l;
      cap_lm[c]   = led_m;
      if (disturb && c == 10) begin
        sw  = 8'hFF;
        btn = 2'b01;
      end
      if (disturb && c == 12) btn = 2'b00;
      step();
    end
    post_busy = {busy_m, busy_l};
    post_done = {done_m, done_l};
    step();
    post2_done = {done_m, done_l};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 2'b01;
    sw  = 8'h3C;
    step();
    step();
    checks++;
    if ({sout_l, busy_l, done_l, led_l, sout_m, busy_m, done_m, led_m} !==
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_vals got=%b/%b/%b/%h exp=1/0/0/00", sout_l, busy_l, done_l, led_l);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy_l, busy_m, sout_l} !== 3'b001) begin
        failures++;
        $display("FAIL held_btn_no_start cyc=%0d got=%b exp=001", i, {busy_l, busy_m, sout_l});
      end
    end
    btn = 2'b00;
    step();
  endtask

  task automatic test_basic();
    capture(8'hA5, 1'b0);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (cap_busy[c] !== 1'b1) begin
        failures++;
        $display("FAIL basic_busy c=%0d got=%b exp=1", c, cap_busy[c]);
      end
      checks++;
      if (cap_sl[c] !== exp_sout(8'b10100101, 1'b0, c)) begin
        failures++;
        $display("FAIL basic_sout c=%0d got=%b exp=%b", c, cap_sl[c],
                 exp_sout(8'b10100101, 1'b0, c));
      end
      checks++;
      if (cap_ll[c] !== exp_led(8'hA5, 1'b1, c)) begin
        failures++;
        $display("FAIL basic_led c=%0d got=%h exp=%h", c, cap_ll[c], exp_led(8'hA5, 1'b1, c));
      end
      checks++;
      if (cap_done[c] !== 1'b0) begin
        failures++;
        $display("FAIL basic_done_early c=%0d got=%b exp=0", c, cap_done[c]);
      end
    end
    checks++;
    if ({post_busy, post_done, post2_done} !== 6'b00_11_00) begin
      failures++;
      $display("FAIL basic_end busy=%b done=%b done_next=%b exp=00/11/00",
               post_busy, post_done, post2_done);
    end
  endtask

  task automatic test_msb();
    logic [7:0] data [2];
    logic [7:0] seq_l [2];
    logic [7:0] seq_m [2];
    data[0] = 8'h81; seq_l[0] = 8'b10000001; seq_m[0] = 8'b10000001;
    data[1] = 8'hC0; seq_l[1] = 8'b00000011; seq_m[1] = 8'b11000000;
    for (int v = 0; v < 2; v++) begin
      capture(data[v], 1'b0);
      for (int c = 0; c < FL; c++) begin
        checks++;
        if (cap_sm[c] !== exp_sout(seq_m[v], 1'b0, c)) begin
          failures++;
          $display("FAIL msb_sout d=%h c=%0d got=%b exp=%b", data[v], c, cap_sm[c],
                   exp_sout(seq_m[v], 1'b0, c));
        end
        checks++;
        if (cap_sl[c] !== exp_sout(seq_l[v], 1'b0, c)) begin
          failures++;
          $display("FAIL lsb_sout d=%h c=%0d got=%b exp=%b", data[v], c, cap_sl[c],
                   exp_sout(seq_l[v], 1'b0, c));
        end
        checks++;
        if (cap_lm[c] !== exp_led(data[v], 1'b0, c)) begin
          failures++;
          $display("FAIL msb_led d=%h c=%0d got=%h exp=%h", data[v], c, cap_lm[c],
                   exp_led(data[v], 1'b0, c));
        end
      end
      checks++;
      if (post_done !== 2'b11) begin
        failures++;
        $display("FAIL msb_done d=%h got=%b exp=11", data[v], post_done);
      end
    end
  endtask

  task automatic test_ignore();
    capture(8'hA5, 1'b1);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (cap_sl[c] !== exp_sout(8'b10100101, 1'b0, c) || cap_busy[c] !== 1'b1) begin
        failures++;
        $display("FAIL ignore_sout c=%0d got=%b busy=%b exp=%b", c, cap_sl[c], cap_busy[c],
                 exp_sout(8'b10100101, 1'b0, c));
      end
    end
    checks++;
    if ({post_busy, post_done} !== 4'b00_11) begin
      failures++;
      $display("FAIL ignore_end busy=%b done=%b exp=00/11", post_busy, post_done);
    end
  endtask

  task automatic test_abort();
    sw  = 8'hA5;
    btn = 2'b01;
    step();
    btn = 2'b00;
    for (int i = 0; i < 17; i++) step();
    checks++;
    if ({busy_l, sout_l} !== 2'b10) begin
      failures++;
      $display("FAIL abort_pre busy/sout got=%b exp=10", {busy_l, sout_l});
    end
    btn = 2'b10;
    step();
    checks++;
    if ({sout_l, busy_l, done_l, led_l, sout_m, busy_m, done_m, led_m} !==
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL abort_idle got=%b/%b/%b/%h exp=1/0/0/00", sout_l, busy_l, done_l, led_l);
    end
    btn = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({done_l, done_m, busy_l, busy_m} !== 4'b0000) begin
        failures++;
        $display("FAIL abort_no_done cyc=%0d got=%b exp=0000", i, {done_l, done_m, busy_l, busy_m});
      end
    end
    btn = 2'b11;
    step();
    checks++;
    if ({busy_l, sout_l} !== 2'b10) begin
      failures++;
      $display("FAIL start_beats_abort got=%b exp=10", {busy_l, sout_l});
    end
    step();
    checks++;
    if ({busy_l, sout_l, done_l} !== 3'b010) begin
      failures++;
      $display("FAIL abort_next_cycle got=%b exp=010", {busy_l, sout_l, done_l});
    end
    btn = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    sw  = 8'hA5;
    btn = 2'b01;
    step();
    btn = 2'b00;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({sout_l, busy_l, done_l, led_l, sout_m, busy_m, done_m, led_m} !==
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_mid got=%b/%b/%b/%h exp=1/0/0/00", sout_l, busy_l, done_l, led_l);
    end
    rst = 1'b0;
    step();
    capture(8'h1E, 1'b0);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (cap_sl[c] !== exp_sout(8'h78, 1'b0, c) || cap_sm[c] !== exp_sout(8'h1E, 1'b0, c)) begin
        failures++;
        $display("FAIL post_reset_sout c=%0d got=%b%b exp=%b%b", c, cap_sl[c], cap_sm[c],
                 exp_sout(8'h78, 1'b0, c), exp_sout(8'h1E, 1'b0, c));
      end
    end
    checks++;
    if ({post_busy, post_done} !== 4'b00_11) begin
      failures++;
      $display("FAIL post_reset_end busy=%b done=%b exp=00/11", post_busy, post_done);
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    capture(8'hA5, 1'b0);
    for (int c = 9 * TICK; c < 10 * TICK; c++) begin
      checks++;
      if ({cap_sl[c], cap_sm[c]} !== 2'b00) begin
        failures++;
        $display("FAIL parity_a5 c=%0d got=%b exp=00", c, {cap_sl[c], cap_sm[c]});
      end
    end
    checks++;
    if ({cap_busy[43], post_busy, post_done} !== 5'b1_00_11) begin
      failures++;
      $display("FAIL parity_len busy43=%b busy44=%b done=%b exp=1/00/11",
               cap_busy[43], post_busy, post_done);
    end
    capture(8'h07, 1'b0);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (cap_sl[c] !== exp_sout(8'hE0, 1'b1, c) || cap_sm[c] !== exp_sout(8'h07, 1'b1, c)) begin
        failures++;
        $display("FAIL parity_07 c=%0d got=%b%b exp=%b%b", c, cap_sl[c], cap_sm[c],
                 exp_sout(8'hE0, 1'b1, c), exp_sout(8'h07, 1'b1, c));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_msb();
    test_ignore();
    test_abort();
    test_reset_mid();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
